uart_tx_frame: RTL

- UART transmitter. It is the send-side counterpart of the team's UART receiver.
- Accepts one byte from a host over a four-phase req/ack handshake.
- Serialises the byte onto a single line using the same bit period and slot order that the receiver samples.
- Sits between the host byte source and the board TX pin.

---
 rtl/uart_tx_frame.sv | 71 +++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: req/ack byte intake, serialised as start | d1..d7,d0 | stop; define UART_TX_STOP2_EN for a second stop bit
module uart_tx_frame #(
  parameter int DIV_MAX = 1,
  parameter int TICKS_PER_BIT = 9
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req,
  input  logic [7:0] data,
  output logic       ack,
  output logic       tx,
  output logic       busy
);
  localparam int DW = DIV_MAX > 0 ? $clog2(DIV_MAX + 1) : 1;
  localparam int CW = TICKS_PER_BIT > 1 ? $clog2(TICKS_PER_BIT) : 1;
  typedef enum logic [3:0] {
    IDLE, HS_ACK, START, SLOT1, SLOT2, SLOT3, SLOT4, SLOT5, SLOT6, SLOT7, SLOT8, STOP
`ifdef UART_TX_STOP2_EN
    , STOP2
`endif
  } state_t;
`ifdef UART_TX_STOP2_EN
  localparam state_t LAST = STOP2;
`else
  localparam state_t LAST = STOP;
`endif
  state_t state;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic [7:0] sh;
  logic tick, slot_end;
  assign tick = div == DW'(DIV_MAX);
  assign slot_end = tick && cnt == CW'(TICKS_PER_BIT - 1);
  // Handshake, bit timing and shifting; the shift register holds the byte pre-rotated
  // so that bit 0 goes out last, and fills with ones so stop slots drive high for free
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      tx <= 1'b1;
      ack <= 1'b0;
      busy <= 1'b0;
      div <= '0;
      cnt <= '0;
      sh <= '0;
    end else if (state == IDLE) begin
      if (req) begin
        state <= HS_ACK;
        ack <= 1'b1;
        busy <= 1'b1;
        sh <= {data[0], data[7:1]};
      end
    end else if (state == HS_ACK) begin
      if (!req) begin
        state <= START;
        ack <= 1'b0;
        tx <= 1'b0;
        div <= '0;
        cnt <= '0;
      end
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        tx <= sh[0];
        sh <= {1'b1, sh[7:1]};
        state <= state == LAST ? IDLE : state_t'(state + 4'd1);
        busy <= state != LAST;
      end
    end
  end
endmodule
